// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg
// Shared definitions for the multi-port register file: the sweep/idle FSM
// state encoding and the entry-count derivation from the address width.
package regfile_mp_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    // Number of entries addressed by an awl-bit address.
    function automatic int depth_of(input int awl);
        return 1 << awl;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if
// Bus bundle between the datapath and the register file.
//   RFWE/RFWA/RFWD : NW write ports (enable, packed addresses, packed data)
//   RFR/RFRD       : NR read ports (packed addresses in, packed data out)
//   RFBUSY         : busy bit of each read address
//   ISSE/ISSA      : issue strobe and destination register
//   CLR            : request a clear sweep
//   RDY            : file idle and usable
// The master drives addresses/data/requests; the slave is the register file.
interface regfile_mp_if #(
    parameter int AWL = 5,
    parameter int DWL = 32,
    parameter int NR  = 2,
    parameter int NW  = 2
);
    logic [NW-1:0]     RFWE;
    logic [NW*AWL-1:0] RFWA;
    logic [NW*DWL-1:0] RFWD;
    logic [NR*AWL-1:0] RFR;
    logic [NR*DWL-1:0] RFRD;
    logic [NR-1:0]     RFBUSY;
    logic              ISSE;
    logic [AWL-1:0]    ISSA;
    logic              CLR;
    logic              RDY;

    modport master (
        output RFWE, RFWA, RFWD, RFR, ISSE, ISSA, CLR,
        input  RFRD, RFBUSY, RDY
    );

    modport slave (
        input  RFWE, RFWA, RFWD, RFR, ISSE, ISSA, CLR,
        output RFRD, RFBUSY, RDY
    );
endinterface

// File: rtl/regfile_bypass.sv
// regfile_bypass
// Combinational read-port mux for one read port.
//   ra         : read address
//   we/wa/wd   : all write ports (enable, packed addresses, packed data)
//   array_data : stored value of entry ra
//   rd         : selected read data
// With WRITE_FIRST the highest-index enabled write port matching ra wins over
// the stored value. With ZERO_REG address 0 always returns zero, no bypass.
module regfile_bypass #(
    parameter int AWL         = 5,
    parameter int DWL         = 32,
    parameter int NW          = 2,
    parameter int WRITE_FIRST = 1,
    parameter int ZERO_REG    = 1
) (
    input  logic [AWL-1:0]    ra,
    input  logic [NW-1:0]     we,
    input  logic [NW*AWL-1:0] wa,
    input  logic [NW*DWL-1:0] wd,
    input  logic [DWL-1:0]    array_data,
    output logic [DWL-1:0]    rd
);

    always_comb begin
        rd = array_data;
        if (WRITE_FIRST != 0) begin
            // Ascending scan: later (higher-index) matches overwrite earlier ones.
            for (int p = 0; p < NW; p++) begin
                if (we[p] && (wa[p*AWL +: AWL] == ra)) begin
                    rd = wd[p*DWL +: DWL];
                end
            end
        end
        if ((ZERO_REG != 0) && (ra == '0)) begin
            rd = '0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
// Parametrised NR-read / NW-write register file with write-first or
// read-first bypass, optional hardwired zero register, per-register busy
// scoreboard and a sequential clear sweep (after reset or on CLR).
//   CLK : clock, rising edge
//   RST : asynchronous active-high reset (FSM, sweep counter, busy bits)
//   bus : regfile_mp_if slave modport (write/read ports, issue, CLR, RDY)
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int AWL         = 5,
    parameter int DWL         = 32,
    parameter int NR          = 2,
    parameter int NW          = 2,
    parameter int WRITE_FIRST = 1,
    parameter int ZERO_REG    = 1
) (
    input  logic         CLK,
    input  logic         RST,
    regfile_mp_if.slave  bus
);

    localparam int DEPTH = depth_of(AWL);

    state_t             state_q, state_d;
    logic [AWL-1:0]     cnt_q, cnt_d;
    logic [DEPTH-1:0]   busy_q, busy_d;
    logic [DWL-1:0]     mem_q [DEPTH];
    logic [DWL-1:0]     mem_d [DEPTH];
    logic               idle;
    logic               sweep;

    // State register: control state is reset asynchronously.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Storage has no reset; the sweep zeroes it instead.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (cnt_q == AWL'(DEPTH - 1)) state_d = ST_IDLE;
            ST_IDLE:  if (bus.CLR)                  state_d = ST_CLEAR;
            default:  state_d = ST_CLEAR;
        endcase
    end

    // Output decode.
    always_comb begin
        idle  = (state_q == ST_IDLE);
        sweep = (state_q == ST_CLEAR);
    end

    assign bus.RDY = idle;

    // The counter only advances while sweeping; it wraps to 0 on the last
    // entry, so it is already 0 whenever a new sweep starts.
    always_comb begin
        cnt_d = sweep ? cnt_q + AWL'(1) : '0;
    end

    // Array update: sweep zeroes one entry per cycle; otherwise the enabled
    // write ports land, ascending so the highest-index port wins.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            mem_d[e] = mem_q[e];
            if (sweep) begin
                if (cnt_q == AWL'(e)) mem_d[e] = '0;
            end else begin
                for (int p = 0; p < NW; p++) begin
                    if (bus.RFWE[p] && (bus.RFWA[p*AWL +: AWL] == AWL'(e)) &&
                        !((ZERO_REG != 0) && (e == 0))) begin
                        mem_d[e] = bus.RFWD[p*DWL +: DWL];
                    end
                end
            end
        end
    end

    // Busy scoreboard: writes clear, issue sets afterwards so set wins on a
    // same-address collision. Starting or running a sweep clears everything.
    always_comb begin
        busy_d = busy_q;
        if (sweep || bus.CLR) begin
            busy_d = '0;
        end else begin
            for (int p = 0; p < NW; p++) begin
                if (bus.RFWE[p]) busy_d[bus.RFWA[p*AWL +: AWL]] = 1'b0;
            end
            if (bus.ISSE && !((ZERO_REG != 0) && (bus.ISSA == '0))) begin
                busy_d[bus.ISSA] = 1'b1;
            end
        end
    end

    // Read ports. The bypass sees the raw write ports; during the sweep all
    // read data and busy bits are forced to zero.
    for (genvar gi = 0; gi < NR; gi++) begin : g_rd
        logic [AWL-1:0] ra;
        logic [DWL-1:0] rd;

        assign ra = bus.RFR[gi*AWL +: AWL];

        regfile_bypass #(
            .AWL         (AWL),
            .DWL         (DWL),
            .NW          (NW),
            .WRITE_FIRST (WRITE_FIRST),
            .ZERO_REG    (ZERO_REG)
        ) u_bypass (
            .ra          (ra),
            .we          (bus.RFWE),
            .wa          (bus.RFWA),
            .wd          (bus.RFWD),
            .array_data  (mem_q[ra]),
            .rd          (rd)
        );

        assign bus.RFRD[gi*DWL +: DWL] = idle ? rd : '0;
        assign bus.RFBUSY[gi]          = idle & busy_q[ra];
    end

endmodule
